vram_arbiter: RTL and testbench

- Shares one single-port 12-bit video RAM (framebuffer) between two clients:
  - the VGA scan-out path, which drives rdn/row_addr/col_addr and consumes d_in;
  - the game-logic pixel writer (tanks, bullets, map tiles).
- Scan-out reads have absolute priority.
- Game writes are buffered in a small FIFO and drained in free RAM slots (blanking, out-of-window pixels).
- Sits between vgac and the VRAM macro, in the vga_clk domain.

---
 rtl/vram_pkg.sv | 13 +
 rtl/vram_wr_fifo.sv | 39 +++
 rtl/vram_arbiter.sv | 109 ++++++++++
 tb/tb_vram_arbiter.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/vram_pkg.sv
// vram_pkg: shared types and constants for the VRAM arbiter
package vram_pkg;
  localparam int VRAM_ADDR_W = 15;
  typedef logic [11:0] rgb444_t;
  typedef logic [VRAM_ADDR_W-1:0] fb_addr_t;
  typedef enum logic [1:0] {SLOT_IDLE, SLOT_READ, SLOT_CLEAR, SLOT_WRITE} slot_owner_e;
  localparam rgb444_t BORDER_COLOR = 12'h000;
  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    rgb444_t data;
  } wq_entry_t;
endpackage

// File: rtl/vram_wr_fifo.sv
// vram_wr_fifo: synchronous FIFO of pending {x,y,data} framebuffer writes
module vram_wr_fifo
  import vram_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W = $bits(wq_entry_t)
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic full,
  output logic empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic push_ok, pop_ok;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign push_ok = push && !full;
  assign pop_ok = pop && !empty;
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  always_ff @(posedge clk)
    if (push_ok) mem[wr_ptr] <= din;
endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one VRAM port between scan-out reads (absolute priority) and FIFO-buffered game writes.
// Define VRAM_CLEAR_EN to add a full-framebuffer clear sweep (clear_req/clear_color/clear_busy).
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int FB_W = 160,
  parameter int FB_H = 120,
  parameter int SCALE_SHIFT = 2,
  parameter int ADDR_W = 15,
  parameter int WQ_DEPTH = 4
) (
  input  logic vga_clk,
  input  logic clr,
  input  logic vga_rdn,
  input  logic [9:0] vga_row,
  input  logic [9:0] vga_col,
  output logic [11:0] vga_pixel,
  input  logic wr_valid,
  output logic wr_ready,
  input  logic [7:0] wr_x,
  input  logic [6:0] wr_y,
  input  logic [11:0] wr_data,
`ifdef VRAM_CLEAR_EN
  input  logic clear_req,
  input  logic [11:0] clear_color,
  output logic clear_busy,
`endif
  output logic mem_en,
  output logic mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [11:0] mem_wdata,
  input  logic [11:0] mem_rdata
);
  localparam logic [10:0] ROW_LIM = 11'(FB_H << SCALE_SHIFT);
  localparam logic [10:0] COL_LIM = 11'(FB_W << SCALE_SHIFT);
  localparam logic [8:0] X_LIM = 9'(FB_W);
  localparam logic [7:0] Y_LIM = 8'(FB_H);
  localparam int QW = $clog2(WQ_DEPTH);
  wq_entry_t head;
  logic [$bits(wq_entry_t)-1:0] head_bits;
  logic full, empty, rd_win, head_ok, rd_v1, rd_v2, sweep;
  logic [QW:0] count;
  logic [ADDR_W-1:0] rd_addr, wr_addr, clr_addr;
  rgb444_t clr_data;
  slot_owner_e owner;
  assign rd_win = !vga_rdn && {1'b0, vga_row} < ROW_LIM && {1'b0, vga_col} < COL_LIM;
  assign rd_addr = ADDR_W'(32'(vga_row >> SCALE_SHIFT) * FB_W + 32'(vga_col >> SCALE_SHIFT));
  assign head = head_bits;
  assign wr_addr = ADDR_W'(32'(head.y) * FB_W + 32'(head.x));
  assign head_ok = {1'b0, head.x} < X_LIM && {1'b0, head.y} < Y_LIM;
  assign wr_ready = count != (QW+1)'(WQ_DEPTH);
  always_comb owner = rd_win ? SLOT_READ : sweep ? SLOT_CLEAR : !empty ? SLOT_WRITE : SLOT_IDLE;
  vram_wr_fifo #(.DEPTH(WQ_DEPTH)) u_fifo (
    .clk(vga_clk),
    .rst(clr),
    .push(wr_valid && !full),
    .pop(owner == SLOT_WRITE),
    .din({wr_x, wr_y, wr_data}),
    .dout(head_bits),
    .full(full),
    .empty(empty),
    .count(count)
  );
  // Out-of-range FIFO heads are still popped, but never touch the RAM.
  always_ff @(posedge vga_clk or posedge clr)
    if (clr) begin
      rd_v1 <= 1'b0;
      rd_v2 <= 1'b0;
      vga_pixel <= BORDER_COLOR;
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
    end else begin
      rd_v1 <= rd_win;
      rd_v2 <= rd_v1;
      vga_pixel <= rd_v2 ? mem_rdata : BORDER_COLOR;
      mem_en <= owner == SLOT_READ || owner == SLOT_CLEAR || (owner == SLOT_WRITE && head_ok);
      mem_we <= owner == SLOT_CLEAR || (owner == SLOT_WRITE && head_ok);
      mem_addr <= owner == SLOT_READ ? rd_addr : owner == SLOT_CLEAR ? clr_addr : wr_addr;
      mem_wdata <= owner == SLOT_CLEAR ? clr_data : head.data;
    end
`ifdef VRAM_CLEAR_EN
  typedef enum logic {CLR_IDLE, CLR_SWEEP} clr_state_e;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FB_W * FB_H - 1);
  clr_state_e state, state_d;
  always_comb
    state_d = state == CLR_IDLE ? (clear_req ? CLR_SWEEP : CLR_IDLE)
            : (!rd_win && clr_addr == LAST) ? CLR_IDLE : CLR_SWEEP;
  always_ff @(posedge vga_clk or posedge clr)
    if (clr) begin
      state <= CLR_IDLE;
      clr_addr <= '0;
      clr_data <= '0;
    end else begin
      state <= state_d;
      if (state == CLR_IDLE && clear_req) begin
        clr_addr <= '0;
        clr_data <= clear_color;
      end else if (owner == SLOT_CLEAR) clr_addr <= clr_addr + 1'b1;
    end
  assign sweep = state == CLR_SWEEP;
  assign clear_busy = sweep;
`else
  assign sweep = 1'b0;
  assign clr_addr = '0;
  assign clr_data = '0;
`endif
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: scoreboard bench for vram_arbiter with a behavioural single-port RAM.
// Build with VRAM_CLEAR_EN defined to also exercise the clear sweep.
module tb_vram_arbiter;
  localparam int FB_W = 160, FB_H = 120, AW = 15;
  logic vga_clk = 0, clr = 1, vga_rdn = 1;
  logic [9:0] vga_row = 0, vga_col = 0;
  logic [11:0] vga_pixel, mem_wdata, mem_rdata;
  logic wr_valid = 0, wr_ready, mem_en, mem_we;
  logic [7:0] wr_x = 0;
  logic [6:0] wr_y = 0;
  logic [11:0] wr_data = 0;
  logic [AW-1:0] mem_addr;
`ifdef VRAM_CLEAR_EN
  logic clear_req = 0, clear_busy;
  logic [11:0] clear_color = 0;
  int e;
`endif
  int cyc = 0, checks = 0, passes = 0;
  typedef struct {int c; logic we; logic [AW-1:0] a; logic [11:0] d;} mexp_t;
  typedef struct {int c; logic [11:0] p;} pexp_t;
  mexp_t mq[$];
  pexp_t pq[$];
  logic [11:0] ram [0:(1<<AW)-1];

  vram_arbiter dut (
    .vga_clk(vga_clk), .clr(clr), .vga_rdn(vga_rdn), .vga_row(vga_row), .vga_col(vga_col),
    .vga_pixel(vga_pixel), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y),
    .wr_data(wr_data),
`ifdef VRAM_CLEAR_EN
    .clear_req(clear_req), .clear_color(clear_color), .clear_busy(clear_busy),
`endif
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 vga_clk = ~vga_clk;

  always @(posedge vga_clk) begin
    cyc <= cyc + 1;
    if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= ram[mem_addr];
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s at cycle %0d: got %0h expected %0h", n, cyc, act, exp);
  endtask

  function automatic logic [11:0] pix(input int a);
    return (a == 323) ? 12'hABC : 12'(a) ^ 12'h5A5;
  endfunction

  task automatic exp_w(input int at, input int a, input logic [11:0] d);
    mexp_t m;
    m.c = at; m.we = 1'b1; m.a = AW'(a); m.d = d;
    mq.push_back(m);
  endtask

  // One cycle of scan-out stimulus, driven between edges; the next edge is cyc+1.
  task automatic tick(input logic rdn, input int row, input int col);
    mexp_t m;
    pexp_t p;
    int a;
    vga_rdn = rdn; vga_row = 10'(row); vga_col = 10'(col);
    p.c = cyc + 3;
    p.p = 12'h000;
    if (!rdn && row < FB_H * 4 && col < FB_W * 4) begin
      a = (row / 4) * FB_W + col / 4;
      m.c = cyc + 1; m.we = 1'b0; m.a = AW'(a); m.d = 12'h000;
      mq.push_back(m);
      p.p = pix(a);
    end
    pq.push_back(p);
    @(negedge vga_clk);
  endtask

  always @(negedge vga_clk) if (!clr) begin
    while (mq.size() > 0 && mq[0].c < cyc) begin
      chk("mem_missing", cyc, mq[0].c);
      mq.delete(0);
    end
    if (mem_en) begin
      if (mq.size() == 0 || mq[0].c != cyc) chk("mem_unexpected", mem_en, 0);
      else begin
        chk("mem_we", mem_we, mq[0].we);
        chk("mem_addr", mem_addr, mq[0].a);
        if (mq[0].we) chk("mem_wdata", mem_wdata, mq[0].d);
        mq.delete(0);
      end
    end
    while (pq.size() > 0 && pq[0].c < cyc) begin
      chk("pixel_missing", cyc, pq[0].c);
      pq.delete(0);
    end
    if (pq.size() > 0 && pq[0].c == cyc) begin
      chk("vga_pixel", vga_pixel, pq[0].p);
      pq.delete(0);
    end
  end

  initial begin
    for (int i = 0; i < (1 << AW); i++) ram[i] = 12'(i) ^ 12'h5A5;
    ram[323] = 12'hABC;
    repeat (3) @(negedge vga_clk);
    chk("rst_pixel", vga_pixel, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_addr", mem_addr, 0);
    clr = 0;
    chk("ready_after_rst", wr_ready, 1);
    // read latency, second address, window corners and border
    tick(0, 8, 12); tick(1, 0, 0); tick(0, 40, 100); tick(1, 0, 0);
    tick(0, 8, 12); tick(0, 100, 650); tick(0, 479, 639); tick(0, 480, 0);
    repeat (3) tick(1, 0, 0);
    // a write waits behind continuous reads
    wr_valid = 1; wr_x = 5; wr_y = 1; wr_data = 12'hF00;
    chk("ready_prio", wr_ready, 1);
    tick(0, 8, 12);
    wr_valid = 0;
    repeat (5) tick(0, 8, 12);
    exp_w(cyc + 1, 165, 12'hF00);
    repeat (3) tick(1, 0, 0);
    // fill the FIFO while reads block it, then drain in order
    for (int i = 0; i < 5; i++) begin
      wr_valid = 1; wr_x = 8'(10 + i); wr_y = 3; wr_data = 12'(12'h100 + i);
      chk("ready_fill", wr_ready, i < 4);
      tick(0, 8, 12);
    end
    wr_valid = 0;
    repeat (2) tick(0, 8, 12);
    for (int i = 0; i < 4; i++) begin
      exp_w(cyc + 1, 490 + i, 12'(12'h100 + i));
      tick(1, 0, 0);
    end
    repeat (3) tick(1, 0, 0);
    chk("ready_drained", wr_ready, 1);
    // reset mid-frame with queued writes that must be discarded
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1; wr_x = 8'(20 + i); wr_y = 4; wr_data = 12'h777;
      tick(0, 8, 12);
    end
    wr_valid = 0;
    repeat (3) tick(0, 8, 12);
    clr = 1;
    #1;
    chk("clr_pixel", vga_pixel, 0);
    chk("clr_mem_en", mem_en, 0);
    chk("clr_mem_we", mem_we, 0);
    chk("clr_mem_addr", mem_addr, 0);
    chk("clr_mem_wdata", mem_wdata, 0);
    mq.delete();
    pq.delete();
    @(negedge vga_clk);
    clr = 0;
    chk("ready_after_clr", wr_ready, 1);
    repeat (8) tick(1, 0, 0);
`ifdef VRAM_CLEAR_EN
    clear_color = 12'h0F0; clear_req = 1; e = cyc + 1;
    for (int i = 0; i < FB_W * FB_H; i++) exp_w(e + 1 + i, i, 12'h0F0);
    tick(1, 0, 0);
    clear_req = 0; clear_color = 12'hFFF;
    chk("busy_start", clear_busy, 1);
    clear_req = 1;
    tick(1, 0, 0);
    clear_req = 0;
    wr_valid = 1; wr_x = 170; wr_y = 0; wr_data = 12'h123;
    tick(1, 0, 0);
    wr_x = 1; wr_data = 12'h00F;
    tick(1, 0, 0);
    wr_valid = 0;
    exp_w(e + FB_W * FB_H + 2, 1, 12'h00F);
    for (int i = 0; i < 19300 && clear_busy; i++) tick(1, 0, 0);
    chk("busy_end", clear_busy, 0);
    chk("busy_end_cycle", cyc, e + FB_W * FB_H);
    repeat (4) tick(1, 0, 0);
`endif
    repeat (3) tick(1, 0, 0);
    chk("mem_left", mq.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
